// File: rtl/uart_itcm_loader_pkg.sv
// Shared definitions for the UART ITCM boot loader: FSM states and default
// framing bytes.
package uart_itcm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RESP   = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_itcm_loader_timer.sv
// Inter-byte timeout: loadable down-counter that parks at zero and flags
// expiry while it sits there.
module uart_itcm_loader_timer #(
    parameter int CYCLES = 100
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic reload,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload wins over counting; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload)
            cnt_d = W'(CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_itcm_loader.sv
// UART boot loader: parses sync / length / LE words / XOR checksum frames
// from the rx byte stream, writes the words into ITCM, answers ACK or NAK and
// keeps the core in reset until a good image has been accepted.
module uart_itcm_loader
    import uart_itcm_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 12,
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_data,
    output logic                  ram_wren,
    output logic                  core_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_lo_q, cnt_lo_d;
    logic [15:0]             words_q, words_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [23:0]             buf_q, buf_d;
    logic [7:0]              csum_q, csum_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]             ram_data_q, ram_data_d;
    logic                    ram_wren_q, ram_wren_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    resp_ack_q, resp_ack_d;
    logic                    core_rst_n_q, core_rst_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    decide, decide_ack;
    logic [15:0]             count;
    logic                    tmr_reload, tmr_expired;

    assign count = {rx_data, cnt_lo_q};

    // Timer restarts on every received byte and on every state change.
    assign tmr_reload = rx_valid || (state_d != state_q);

    uart_itcm_loader_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .reload  (tmr_reload),
        .expired (tmr_expired)
    );

    // Next-state and datapath: frame parsing, word assembly, response.
    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        words_d      = words_q;
        byte_idx_d   = byte_idx_q;
        buf_d        = buf_q;
        csum_d       = csum_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        ram_wren_d   = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        resp_ack_d   = resp_ack_q;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        decide       = 1'b0;
        decide_ack   = 1'b0;

        // Address advances the cycle after each write strobe.
        if (ram_wren_q)
            ram_addr_d = ram_addr_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d      = ST_LEN_LO;
                    csum_d       = 8'h00;
                    words_d      = 16'd0;
                    byte_idx_d   = 2'd0;
                    ram_addr_d   = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    core_rst_n_d = 1'b0;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end else if (tmr_expired) begin
                    decide = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    words_d = count;
                    if (32'(count) > (32'd1 << ADDR_WIDTH))
                        decide = 1'b1;
                    else if (count == 16'd0)
                        state_d = ST_CSUM;
                    else
                        state_d = ST_DATA;
                end else if (tmr_expired) begin
                    decide = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            ram_data_d = {rx_data, buf_q};
                            ram_wren_d = 1'b1;
                            words_d    = words_q - 16'd1;
                            if (words_q == 16'd1)
                                state_d = ST_CSUM;
                        end
                    endcase
                end else if (tmr_expired) begin
                    decide = 1'b1;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    decide     = 1'b1;
                    decide_ack = (rx_data == csum_q);
                end else if (tmr_expired) begin
                    decide = 1'b1;
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    if (resp_ack_q) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        core_rst_n_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any frame verdict launches the response byte next cycle.
        if (decide) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = decide_ack ? ACK_BYTE : NAK_BYTE;
            resp_ack_d = decide_ack;
        end
    end

    // State and output registers; reset aborts any frame silently.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_lo_q     <= 8'h00;
            words_q      <= 16'd0;
            byte_idx_q   <= 2'd0;
            buf_q        <= 24'h0;
            csum_q       <= 8'h00;
            ram_addr_q   <= '0;
            ram_data_q   <= 32'h0;
            ram_wren_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            resp_ack_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            words_q      <= words_d;
            byte_idx_q   <= byte_idx_d;
            buf_q        <= buf_d;
            csum_q       <= csum_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_wren_q   <= ram_wren_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            resp_ack_q   <= resp_ack_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign ram_wren   = ram_wren_q;
    assign core_rst_n = core_rst_n_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_uart_itcm_loader.sv
// Directed bench for uart_itcm_loader: expected ITCM writes and tx bytes are
// queued as stimulus is driven and popped when the DUT produces them.
module tb_uart_itcm_loader;

    localparam int AW = 4;
    localparam int TO = 100;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b1;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          ram_wren;
    logic          core_rst_n;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    uart_itcm_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .core_rst_n (core_rst_n),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] tq[$];
    logic [7:0] csum;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: note whether a tx handshake happens at this edge, then
    // check write strobes and handshakes against the scoreboard.
    task automatic step();
        logic       hs;
        logic [7:0] td;
        wr_t        w;
        logic [7:0] t;
        hs = tx_valid && tx_ready;
        td = tx_data;
        @(posedge clk_in);
        #1;
        if (hs) begin
            chk("tx_expected", 32'(tq.size() > 0), 32'd1);
            if (tq.size() > 0) begin
                t = tq.pop_front();
                chk("tx_data", 32'(td), 32'(t));
            end
        end
        if (ram_wren) begin
            chk("wr_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(w.addr));
                chk("wr_data", ram_data, w.data);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        csum = csum ^ b;
        send_byte(b);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
        wq.push_back({a, w});
        for (int i = 0; i < 4; i++) send_data(w[8*i +: 8]);
    endtask

    task automatic wait_tx(input int budget);
        int n;
        n = 0;
        while (tq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("tx_wait_budget", 32'(tq.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_data"}, ram_data, 32'd0);
        chk({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(load_busy), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Noise, then a good two-word frame (data XOR is 8'h2A)
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("noise_busy", 32'(load_busy), 32'd0);
        send_byte(8'hA5);
        chk("sync_busy", 32'(load_busy), 32'd1);
        chk("sync_core_rst", 32'(core_rst_n), 32'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        csum = 8'h00;
        send_word(4'd0, 32'h12345678);
        chk("wren_latency", 32'(ram_wren), 32'd1);
        send_word(4'd1, 32'hDEADBEEF);
        chk("good_csum_model", 32'(csum), 32'h2A);
        tx_ready = 1'b0;
        tq.push_back(8'h06);
        send_byte(csum);
        chk("resp_valid_rise", 32'(tx_valid), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("resp_hold_valid", 32'(tx_valid), 32'd1);
        chk("resp_hold_data", 32'(tx_data), 32'h06);
        chk("resp_hold_core_rst", 32'(core_rst_n), 32'd0);
        tx_ready = 1'b1;
        wait_tx(5);
        chk("ack_tx_valid_fall", 32'(tx_valid), 32'd0);
        chk("ack_core_rst", 32'(core_rst_n), 32'd1);
        chk("ack_done", 32'(load_done), 32'd1);
        chk("ack_busy", 32'(load_busy), 32'd0);

        // DONE: noise ignored, sync re-arms, then zero-length frame
        send_byte(8'h33);
        chk("done_noise", 32'(load_done), 32'd1);
        send_byte(8'hA5);
        chk("rearm_core_rst", 32'(core_rst_n), 32'd0);
        chk("rearm_done", 32'(load_done), 32'd0);
        chk("rearm_busy", 32'(load_busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        tq.push_back(8'h06);
        send_byte(8'h00);
        wait_tx(5);
        chk("zero_len_done", 32'(load_done), 32'd1);
        chk("zero_len_core_rst", 32'(core_rst_n), 32'd1);

        // Bad checksum: both words still written, NAK
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        csum = 8'h00;
        send_word(4'd0, 32'h12345678);
        send_word(4'd1, 32'hDEADBEEF);
        tq.push_back(8'h15);
        send_byte(8'h01);
        wait_tx(5);
        chk("bad_csum_err", 32'(load_err), 32'd1);
        chk("bad_csum_core_rst", 32'(core_rst_n), 32'd0);
        chk("bad_csum_done", 32'(load_done), 32'd0);
        chk("bad_csum_busy", 32'(load_busy), 32'd0);

        // Largest legal count fills the whole ITCM (addresses 0..15)
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h00);
        csum = 8'h00;
        for (int i = 0; i < 16; i++) send_word(AW'(i), $urandom);
        tq.push_back(8'h06);
        send_byte(csum);
        wait_tx(5);
        chk("full_done", 32'(load_done), 32'd1);
        chk("full_err", 32'(load_err), 32'd0);

        // Count one past the depth: immediate NAK, no writes
        send_byte(8'hA5);
        send_byte(8'h11);
        tq.push_back(8'h15);
        send_byte(8'h00);
        chk("too_large_valid", 32'(tx_valid), 32'd1);
        wait_tx(5);
        chk("too_large_err", 32'(load_err), 32'd1);

        // Timeout mid-word: NAK in the 101st cycle after the last byte
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_data(8'h11);
        send_data(8'h22);
        tx_ready = 1'b0;
        tq.push_back(8'h15);
        n = 0;
        while (!tx_valid && n < 3 * TO) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO + 1));
        chk("timeout_tx_data", 32'(tx_data), 32'h15);
        tx_ready = 1'b1;
        wait_tx(5);
        chk("timeout_err", 32'(load_err), 32'd1);

        // Reset mid-DATA: silent abort
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_data(8'h01);
        send_data(8'h02);
        rst_n = 1'b0;
        step();
        chk_reset("abort");
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_valid) n++;
        end
        chk("abort_no_tx", 32'(n), 32'd0);
        chk("abort_busy", 32'(load_busy), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
